// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative RV32M/RV64M multiply/divide unit with tag, valid/ready and kill
module riscv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            r_state;
  logic [2:0]        r_f3;
  logic [TAG_W-1:0]  r_tag;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_hi, r_lo, r_b, r_res;
  logic              r_neg_q, r_neg_r, r_out_valid;
  logic              w_acc, w_div, w_s1, w_s2, w_n1, w_n2, w_dz, w_ovf, w_ge;
  logic [XLEN-1:0]   w_m1, w_m2, w_fast_res, w_hi_n, w_lo_n, w_quot, w_rem, w_res;
  logic [XLEN:0]     w_sum, w_rsh;
  logic [2*XLEN-1:0] w_p, w_prod;
  assign in_ready_o  = (r_state == IDLE) && !rst_i;
  assign out_valid_o = r_out_valid;
  assign result_o    = r_res;
  assign tag_o       = r_tag;
  assign busy_o      = r_state != IDLE;
  assign w_acc = in_valid_i && in_ready_o && !kill_i;
  // Operand decode: signedness per op, magnitudes, and the two divide corner cases that skip iteration
  assign w_div = funct3_i[2];
  assign w_s1  = w_div ? !funct3_i[0] : (funct3_i == 3'b001 || funct3_i == 3'b010);
  assign w_s2  = w_div ? !funct3_i[0] : (funct3_i == 3'b001);
  assign w_n1  = w_s1 && rs1_i[XLEN-1];
  assign w_n2  = w_s2 && rs2_i[XLEN-1];
  assign w_m1  = w_n1 ? -rs1_i : rs1_i;
  assign w_m2  = w_n2 ? -rs2_i : rs2_i;
  assign w_dz  = w_div && rs2_i == '0;
  assign w_ovf = w_div && !funct3_i[0] && rs1_i == MIN_INT && &rs2_i;
  assign w_fast_res = w_dz ? (funct3_i[1] ? rs1_i : '1) : (funct3_i[1] ? '0 : MIN_INT);
  // One iteration: multiply adds r_b into the high half then shifts right; divide shifts left and subtracts when it fits
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_rsh  = {r_hi, r_lo[XLEN-1]};
  assign w_ge   = w_rsh >= {1'b0, r_b};
  assign w_hi_n = r_f3[2] ? (w_ge ? w_rsh[XLEN-1:0] - r_b : w_rsh[XLEN-1:0]) : w_sum[XLEN:1];
  assign w_lo_n = r_f3[2] ? {r_lo[XLEN-2:0], w_ge} : {w_sum[0], r_lo[XLEN-1:1]};
  // Sign fix-up on the final iteration's values and result select
  assign w_p    = {w_hi_n, w_lo_n};
  assign w_prod = r_neg_q ? -w_p : w_p;
  assign w_quot = r_neg_q ? -w_lo_n : w_lo_n;
  assign w_rem  = r_neg_r ? -w_hi_n : w_hi_n;
  assign w_res  = r_f3[2] ? (r_f3[1] ? w_rem : w_quot) :
                  (r_f3[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
  // Control FSM and datapath registers: reset beats kill beats normal operation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_tag       <= '0;
      r_cnt       <= '0;
      r_f3        <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
    end else if (kill_i) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else if (r_state == IDLE) begin
      if (w_acc) begin
        r_f3    <= funct3_i;
        r_tag   <= tag_i;
        r_hi    <= '0;
        r_lo    <= w_div ? w_m1 : w_m2;
        r_b     <= w_div ? w_m2 : w_m1;
        r_neg_q <= w_n1 ^ w_n2;
        r_neg_r <= w_n1;
        r_cnt   <= '0;
        if (w_dz || w_ovf) begin
          r_res       <= w_fast_res;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end else begin
          r_state <= BUSY;
        end
      end
    end else if (r_state == BUSY) begin
      r_hi <= w_hi_n;
      r_lo <= w_lo_n;
      if (r_cnt == CW'(XLEN-1)) begin
        r_res       <= w_res;
        r_out_valid <= 1'b1;
        r_state     <= DONE;
        r_cnt       <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
      r_state     <= IDLE;
    end
  end
endmodule
